// File: rtl/gone_fishin_pkg.sv
// Shared definitions for the lookup-ROM read path.
// Contents: ROM geometry and latency, requester port numbers, the owner
// encoding used by the read arbiter, and the {valid, port} tag that follows
// each accepted read down the ROM latency pipeline.
package gone_fishin_pkg;

  localparam int ROM_ADDR_W  = 6;
  localparam int USER_DATA_W = 16;  // user ROM words are zero-extended to PASS_DATA_W
  localparam int PASS_DATA_W = 20;
  localparam int ROM_RD_LAT  = 2;   // clk edges from rom_addr change to valid rom_data

  localparam logic PORT_ACCESS = 1'b0;  // access controller
  localparam logic PORT_SCORE  = 1'b1;  // score keeper

  typedef enum logic [1:0] {
    OWNER_ACCESS = 2'd0,
    OWNER_SCORE  = 2'd1,
    OWNER_NONE   = 2'd2
  } owner_e;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  function automatic owner_e owner_of(input logic port);
    return (port == PORT_SCORE) ? OWNER_SCORE : OWNER_ACCESS;
  endfunction

endpackage

// File: rtl/rom_read_tag_pipe.sv
// Tag pipeline for the shared ROM read path.
// Each accepted read enters as {valid, port} and leaves DEPTH edges later,
// exactly when the ROM output holds that read's word.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset; empties the pipeline
//   tag_i   in   tag of the read accepted at this edge (valid=0 when none)
//   tag_o   out  tag whose data is on rom_data now
//   busy_o  out  OR of all stage valid bits
module rom_read_tag_pipe
  import gone_fishin_pkg::*;
#(
  parameter int DEPTH = ROM_RD_LAT + 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o,
  output logic    busy_o
);

  rd_tag_t stage_q [DEPTH];

  // NOTE: every stage is reset, not just the valid of the last one; a reset
  // has to discard all in-flight reads so none of them ever returns rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_o = busy_o | stage_q[i].valid;
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of one synchronous lookup ROM.
// Port 0 is the access controller, port 1 the score keeper. Grants are
// combinational; an accepted read registers its address onto rom_addr and
// its tag into the latency pipeline, and the returned word is captured into
// rdata with a one-cycle rvalid pulse on the issuing port. A requester that
// asserts lock with an accepted read owns the ROM until it drops lock.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0/lock0/addr0/gnt0    port 0 request, lock, address, grant
//   rvalid0                  port 0 read data valid pulse
//   req1/lock1/addr1/gnt1    port 1 equivalents
//   rvalid1                  port 1 read data valid pulse
//   rdata                    shared read data, held between pulses
//   rom_addr / rom_data      ROM address (registered) and ROM output word
//   busy                     any accepted read still in flight
module rom_read_arbiter
  import gone_fishin_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = PASS_DATA_W,
  parameter int RD_LAT = ROM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  owner_e            owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;

  logic    accept, acc_port, acc_lock;
  rd_tag_t tag_in, tag_out;

  // Grant from the pre-edge owner; a port releasing at this edge cannot
  // hand over in the same cycle, the other port wins the cycle after.
  // NOTE: both grants get a default before the case, so no path through the
  // block leaves them unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (owner_q)
        OWNER_ACCESS: gnt0 = req0;
        OWNER_SCORE:  gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            gnt0 = (rr_ptr_q == PORT_ACCESS);
            gnt1 = (rr_ptr_q == PORT_SCORE);
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  assign accept   = (req0 & gnt0) | (req1 & gnt1);
  assign acc_port = gnt1 ? PORT_SCORE : PORT_ACCESS;
  assign acc_lock = gnt1 ? lock1 : lock0;

  always_comb begin
    tag_in.valid = accept;
    tag_in.port  = acc_port;
  end

  rom_read_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_i  (tag_in),
    .tag_o  (tag_out),
    .busy_o (busy)
  );

  always_comb begin
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    rdata_d    = rdata_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;

    // Release first; an accept with lock set re-claims below, so an owner
    // streaming with lock held never passes through NONE.
    if ((owner_q == OWNER_ACCESS && !lock0) || (owner_q == OWNER_SCORE && !lock1))
      owner_d = OWNER_NONE;

    if (accept) begin
      rom_addr_d = (acc_port == PORT_SCORE) ? addr1 : addr0;
      rr_ptr_d   = ~acc_port;
      if (acc_lock) owner_d = owner_of(acc_port);
    end

    if (tag_out.valid) begin
      rdata_d   = rom_data;
      rvalid0_d = (tag_out.port == PORT_ACCESS);
      rvalid1_d = (tag_out.port == PORT_SCORE);
    end
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWNER_NONE;
      rr_ptr_q   <= PORT_ACCESS;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      rdata_q    <= rdata_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rdata    = rdata_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level model that keeps
// a queue of outstanding reads with their due edge.
module tb_rom_read_arbiter;
  import gone_fishin_pkg::*;

  localparam int AW  = ROM_ADDR_W;
  localparam int DW  = PASS_DATA_W;
  localparam int LAT = ROM_RD_LAT + 1;  // accept edge to capture edge

  logic          clk = 1'b0;
  logic          rst, req0, lock0, req1, lock1;
  logic [AW-1:0] addr0, addr1, rom_addr;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata, rom_data, rom_d1;
  logic [DW-1:0] rom_mem [2**AW];

  int vectors = 0;
  int miscompares = 0;

  rom_read_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .lock0(lock0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM with two edges of latency from rom_addr to rom_data.
  always @(posedge clk) begin
    rom_d1   <= rom_mem[rom_addr];
    rom_data <= rom_d1;
  end

  typedef struct packed {
    logic          rst;
    logic          req0;
    logic          lock0;
    logic [AW-1:0] addr0;
    logic          req1;
    logic          lock1;
    logic [AW-1:0] addr1;
  } stim_t;

  typedef struct {
    int            due;
    bit            port;
    logic [AW-1:0] addr;
  } rd_t;

  // Reference model state.
  int            m_owner = -1;  // -1 = nobody
  bit            m_rr = 1'b0;
  rd_t           m_q[$];
  int            m_edge = 0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_rv0 = 1'b0, m_rv1 = 1'b0, m_busy = 1'b0;
  logic [AW-1:0] m_rom_addr = '0;

  function automatic stim_t mk(input bit r, input bit q0, input bit l0, input int a0,
                               input bit q1, input bit l1, input int a1);
    stim_t s;
    s.rst = r; s.req0 = q0; s.lock0 = l0; s.addr0 = AW'(a0);
    s.req1 = q1; s.lock1 = l1; s.addr1 = AW'(a1);
    return s;
  endfunction

  function automatic void m_grant(input stim_t s, output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (s.rst) return;
    if (m_owner == 0)      g0 = s.req0;
    else if (m_owner == 1) g1 = s.req1;
    else if (s.req0 && s.req1) begin
      if (m_rr) g1 = 1'b1; else g0 = 1'b1;
    end else begin
      g0 = s.req0;
      g1 = s.req1;
    end
  endfunction

  // Advance the model across one clock edge with stimulus s.
  task automatic m_step(input stim_t s);
    bit g0, g1;
    int new_owner;
    rd_t rd;
    if (s.rst) begin
      m_owner = -1; m_rr = 1'b0; m_q.delete();
      m_rdata = '0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rom_addr = '0;
    end else begin
      m_grant(s, g0, g1);
      new_owner = m_owner;
      if ((m_owner == 0 && !s.lock0) || (m_owner == 1 && !s.lock1)) new_owner = -1;
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == m_edge) begin
        rd = m_q.pop_front();
        m_rdata = rom_mem[rd.addr];
        if (rd.port) m_rv1 = 1'b1; else m_rv0 = 1'b1;
      end
      if (g0 || g1) begin
        rd.due  = m_edge + LAT;
        rd.port = g1;
        rd.addr = g1 ? s.addr1 : s.addr0;
        m_q.push_back(rd);
        m_rom_addr = rd.addr;
        m_rr = !g1;
        if (g1 ? s.lock1 : s.lock0) new_owner = g1 ? 1 : 0;
      end
      m_owner = new_owner;
    end
    m_edge++;
    m_busy = (m_q.size() != 0);
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst; req0 = s.req0; lock0 = s.lock0; addr0 = s.addr0;
    req1 = s.req1; lock1 = s.lock1; addr1 = s.addr1;
  endtask

  task automatic test_reset();
    stim_t sv[$];
    bit eg0, eg1;
    sv.push_back(mk(1, 1, 1, 5, 1, 0, 9));
    sv.push_back(mk(1, 0, 0, 0, 1, 1, 3));
    sv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (sv[i]) begin
      apply(sv[i]);
      #1;
      m_grant(sv[i], eg0, eg1);
      vectors++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        miscompares++;
        $display("FAIL reset_gnt c%0d: got %b%b exp %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      @(posedge clk); m_step(sv[i]); @(negedge clk);
      vectors++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || busy !== 1'b0 || rdata !== '0 || rom_addr !== '0) begin
        miscompares++;
        $display("FAIL reset_state c%0d: got rv=%b%b busy=%b rdata=%h addr=%0d exp all zero",
                 i, rvalid0, rvalid1, busy, rdata, rom_addr);
      end
    end
  endtask

  task automatic test_single();
    stim_t sv[$];
    bit eg0, eg1;
    int n_rv0 = 0, n_rv1 = 0;
    sv.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    sv.push_back(mk(0, 1, 0, 3, 0, 0, 0));
    for (int k = 0; k < 6; k++) sv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (sv[i]) begin
      apply(sv[i]);
      #1;
      m_grant(sv[i], eg0, eg1);
      vectors++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        miscompares++;
        $display("FAIL single_gnt c%0d: got %b%b exp %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      @(posedge clk); m_step(sv[i]); @(negedge clk);
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata !== m_rdata || busy !== m_busy || rom_addr !== m_rom_addr) begin
        miscompares++;
        $display("FAIL single_out c%0d: got rv=%b%b rdata=%h busy=%b addr=%0d exp rv=%b%b rdata=%h busy=%b addr=%0d",
                 i, rvalid0, rvalid1, rdata, busy, rom_addr, m_rv0, m_rv1, m_rdata, m_busy, m_rom_addr);
      end
      if (i == 1) begin
        vectors++;
        if (rom_addr !== AW'(3)) begin
          miscompares++;
          $display("FAIL single_rom_addr: got %0d exp 3", rom_addr);
        end
      end
      if (i == 1 + LAT) begin
        vectors++;
        if (rvalid0 !== 1'b1 || rdata !== rom_mem[3]) begin
          miscompares++;
          $display("FAIL single_data: got rv0=%b rdata=%h exp rv0=1 rdata=%h", rvalid0, rdata, rom_mem[3]);
        end
      end
      n_rv0 += int'(rvalid0 === 1'b1);
      n_rv1 += int'(rvalid1 === 1'b1);
    end
    vectors++;
    if (n_rv0 != 1 || n_rv1 != 0) begin
      miscompares++;
      $display("FAIL single_pulses: got rv0 x%0d rv1 x%0d exp 1 and 0", n_rv0, n_rv1);
    end
  endtask

  task automatic test_alternate();
    stim_t sv[$];
    bit eg0, eg1;
    bit alt_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    sv.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      sv.push_back(mk(0, 1, 0, $urandom_range(0, 63), 1, 0, $urandom_range(0, 63)));
    for (int k = 0; k < 5; k++) sv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (sv[i]) begin
      apply(sv[i]);
      #1;
      m_grant(sv[i], eg0, eg1);
      vectors++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        miscompares++;
        $display("FAIL alt_gnt c%0d: got %b%b exp %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      if (i >= 1 && i <= 4) begin
        vectors++;
        if (gnt1 !== alt_exp[i-1] || gnt0 !== !alt_exp[i-1]) begin
          miscompares++;
          $display("FAIL alt_order c%0d: got gnt0/1=%b%b exp winner port %0d", i, gnt0, gnt1, alt_exp[i-1]);
        end
      end
      @(posedge clk); m_step(sv[i]); @(negedge clk);
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata !== m_rdata || busy !== m_busy || rom_addr !== m_rom_addr) begin
        miscompares++;
        $display("FAIL alt_out c%0d: got rv=%b%b rdata=%h busy=%b addr=%0d exp rv=%b%b rdata=%h busy=%b addr=%0d",
                 i, rvalid0, rvalid1, rdata, busy, rom_addr, m_rv0, m_rv1, m_rdata, m_busy, m_rom_addr);
      end
    end
  endtask

  task automatic test_lock();
    stim_t sv[$];
    bit eg0, eg1;
    int n_rv0 = 0;
    sv.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) sv.push_back(mk(0, 1, 1, k, 1, 0, 40));
    sv.push_back(mk(0, 0, 0, 0, 1, 0, 40));  // lock0 drops here
    sv.push_back(mk(0, 0, 0, 0, 1, 0, 40));  // port 1 wins now
    for (int k = 0; k < 5; k++) sv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (sv[i]) begin
      apply(sv[i]);
      #1;
      m_grant(sv[i], eg0, eg1);
      vectors++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        miscompares++;
        $display("FAIL lock_gnt c%0d: got %b%b exp %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      if (i >= 1 && i <= 8) begin
        vectors++;
        if (gnt1 !== (i == 8)) begin
          miscompares++;
          $display("FAIL lock_block c%0d: got gnt1=%b exp %b", i, gnt1, (i == 8));
        end
      end
      @(posedge clk); m_step(sv[i]); @(negedge clk);
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata !== m_rdata || busy !== m_busy || rom_addr !== m_rom_addr) begin
        miscompares++;
        $display("FAIL lock_out c%0d: got rv=%b%b rdata=%h busy=%b addr=%0d exp rv=%b%b rdata=%h busy=%b addr=%0d",
                 i, rvalid0, rvalid1, rdata, busy, rom_addr, m_rv0, m_rv1, m_rdata, m_busy, m_rom_addr);
      end
      if (i >= 1 + LAT && i <= 6 + LAT) n_rv0 += int'(rvalid0 === 1'b1);
    end
    vectors++;
    if (n_rv0 != 6) begin
      miscompares++;
      $display("FAIL lock_stream: got %0d consecutive rvalid0 exp 6", n_rv0);
    end
  endtask

  task automatic test_reset_mid();
    stim_t sv[$];
    bit eg0, eg1;
    int n_rv1 = 0;
    sv.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    sv.push_back(mk(0, 0, 0, 0, 1, 1, 5));
    sv.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 6; k++) sv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    sv.push_back(mk(0, 0, 0, 0, 1, 0, 9));   // index 9: granted at once
    for (int k = 0; k < 5; k++) sv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (sv[i]) begin
      apply(sv[i]);
      #1;
      m_grant(sv[i], eg0, eg1);
      vectors++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        miscompares++;
        $display("FAIL rstmid_gnt c%0d: got %b%b exp %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      if (i == 9) begin
        vectors++;
        if (gnt1 !== 1'b1) begin
          miscompares++;
          $display("FAIL rstmid_regrant: got gnt1=%b exp 1", gnt1);
        end
      end
      @(posedge clk); m_step(sv[i]); @(negedge clk);
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata !== m_rdata || busy !== m_busy || rom_addr !== m_rom_addr) begin
        miscompares++;
        $display("FAIL rstmid_out c%0d: got rv=%b%b rdata=%h busy=%b addr=%0d exp rv=%b%b rdata=%h busy=%b addr=%0d",
                 i, rvalid0, rvalid1, rdata, busy, rom_addr, m_rv0, m_rv1, m_rdata, m_busy, m_rom_addr);
      end
      if (i >= 2 && i <= 8) n_rv1 += int'(rvalid1 === 1'b1);
      if (i == 2) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL rstmid_busy: got busy=%b exp 0", busy);
        end
      end
    end
    vectors++;
    if (n_rv1 != 0) begin
      miscompares++;
      $display("FAIL rstmid_ghost: got %0d rvalid1 pulses exp 0", n_rv1);
    end
  endtask

  task automatic test_back_to_back();
    stim_t sv[$];
    bit eg0, eg1;
    sv.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    sv.push_back(mk(0, 1, 0, 2, 0, 0, 0));
    sv.push_back(mk(0, 1, 0, 4, 0, 0, 0));
    for (int k = 0; k < 5; k++) sv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (sv[i]) begin
      apply(sv[i]);
      #1;
      m_grant(sv[i], eg0, eg1);
      vectors++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        miscompares++;
        $display("FAIL b2b_gnt c%0d: got %b%b exp %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      @(posedge clk); m_step(sv[i]); @(negedge clk);
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata !== m_rdata || busy !== m_busy || rom_addr !== m_rom_addr) begin
        miscompares++;
        $display("FAIL b2b_out c%0d: got rv=%b%b rdata=%h busy=%b addr=%0d exp rv=%b%b rdata=%h busy=%b addr=%0d",
                 i, rvalid0, rvalid1, rdata, busy, rom_addr, m_rv0, m_rv1, m_rdata, m_busy, m_rom_addr);
      end
      if (i == 1 + LAT || i == 2 + LAT) begin
        vectors++;
        if (rvalid0 !== 1'b1 || rdata !== rom_mem[(i == 1 + LAT) ? 2 : 4]) begin
          miscompares++;
          $display("FAIL b2b_data c%0d: got rv0=%b rdata=%h exp rv0=1 rdata=%h",
                   i, rvalid0, rdata, rom_mem[(i == 1 + LAT) ? 2 : 4]);
        end
      end
      if (i == 3 + LAT) begin
        vectors++;
        if (busy !== 1'b0 || rvalid0 !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_idle: got busy=%b rv0=%b exp 0 0", busy, rvalid0);
        end
      end
    end
  endtask

  task automatic test_lock_idle();
    stim_t sv[$];
    bit eg0, eg1;
    sv.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    sv.push_back(mk(0, 0, 0, 0, 1, 1, 7));            // port 1 takes ownership
    for (int k = 0; k < 10; k++) sv.push_back(mk(0, 1, 0, 11, 0, 1, 0));
    sv.push_back(mk(0, 1, 0, 11, 0, 0, 0));           // index 12: lock1 falls
    sv.push_back(mk(0, 1, 0, 11, 0, 0, 0));           // index 13: port 0 wins
    for (int k = 0; k < 5; k++) sv.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (sv[i]) begin
      apply(sv[i]);
      #1;
      m_grant(sv[i], eg0, eg1);
      vectors++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        miscompares++;
        $display("FAIL lkidle_gnt c%0d: got %b%b exp %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      if (i >= 2 && i <= 13) begin
        vectors++;
        if (gnt0 !== (i == 13)) begin
          miscompares++;
          $display("FAIL lkidle_block c%0d: got gnt0=%b exp %b", i, gnt0, (i == 13));
        end
      end
      @(posedge clk); m_step(sv[i]); @(negedge clk);
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata !== m_rdata || busy !== m_busy || rom_addr !== m_rom_addr) begin
        miscompares++;
        $display("FAIL lkidle_out c%0d: got rv=%b%b rdata=%h busy=%b addr=%0d exp rv=%b%b rdata=%h busy=%b addr=%0d",
                 i, rvalid0, rvalid1, rdata, busy, rom_addr, m_rv0, m_rv1, m_rdata, m_busy, m_rom_addr);
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    bit eg0, eg1;
    for (int i = 0; i < 400; i++) begin
      s = mk($urandom_range(0, 49) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 63),
             $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 63));
      apply(s);
      #1;
      m_grant(s, eg0, eg1);
      vectors++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        miscompares++;
        $display("FAIL rand_gnt c%0d: got %b%b exp %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      @(posedge clk); m_step(s); @(negedge clk);
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata !== m_rdata || busy !== m_busy || rom_addr !== m_rom_addr) begin
        miscompares++;
        $display("FAIL rand_out c%0d: got rv=%b%b rdata=%h busy=%b addr=%0d exp rv=%b%b rdata=%h busy=%b addr=%0d",
                 i, rvalid0, rvalid1, rdata, busy, rom_addr, m_rv0, m_rv1, m_rdata, m_busy, m_rom_addr);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 2**AW; a++) rom_mem[a] = DW'($urandom);
    rom_d1 = '0;
    rom_data = '0;
    apply(mk(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_reset_mid();
    test_back_to_back();
    test_lock_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end exp end of tests");
    $fatal(1, "timeout");
  end

endmodule
